// File: rtl/uart_pkg.sv
// Shared types and constants for the uart1rx receiver.
// Frame: 1 start, 8 data LSB first, 1 stop.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam int DATA_BITS = 8;

  function automatic int half_div(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/uart1rx_if.sv
// CPU-side view of the receiver: serial line in,
// last byte and sticky interrupt out.
interface uart1rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic                 interrupt_clear;
  logic [DATA_BITS-1:0] data;
  logic                 interrupt;

  modport master (
    output rx,
    output interrupt_clear,
    input  data,
    input  interrupt
  );

  modport slave (
    input  rx,
    input  interrupt_clear,
    output data,
    output interrupt
  );

endinterface

// File: rtl/uart1rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous input,
// with a configurable reset value.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] ff;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff <= {2{RESET_VAL}};
    end else begin
      ff <= {ff[0], d};
    end
  end

  assign q = ff[1];

endmodule

// File: rtl/uart1rx.sv
// 8N1 UART receiver with mid-bit sampling via a
// per-bit divider and a sticky byte-received flag.
module uart1rx
  import uart_pkg::*;
#(
  parameter int CLOCK_DIV          = 16,
  parameter int CLOCK_COUNTER_BITS = 8
) (
  input  logic      clk,
  input  logic      reset,
  uart1rx_if.slave  bus
);

  localparam int W    = CLOCK_COUNTER_BITS;
  localparam int HALF = half_div(CLOCK_DIV);
  localparam int BW   = $clog2(DATA_BITS);

  localparam logic [W-1:0]  HALF_END = W'(HALF - 1);
  localparam logic [W-1:0]  BIT_END  = W'(CLOCK_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  logic                 rx_s;
  state_t               state;
  state_t               next;
  logic [W-1:0]         div;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] data_q;
  logic                 irq;
  logic                 sample;
  logic                 div_clr;
  logic                 shift_en;
  logic                 load;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (bus.rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE:      if (!rx_s) next = START;
      START:     if (sample) next = rx_s ? IDLE : DATA;
      DATA:      if (sample && bit_cnt == LAST_BIT) next = STOP;
      STOP:      if (sample) next = rx_s ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rx_s) next = IDLE;
      default:   next = IDLE;
    endcase
  end

  // Divider is held at zero outside the timed states.
  always_comb begin
    sample   = 1'b0;
    div_clr  = 1'b1;
    shift_en = 1'b0;
    load     = 1'b0;
    unique case (state)
      START: begin
        sample  = (div == HALF_END);
        div_clr = sample;
      end
      DATA: begin
        sample   = (div == BIT_END);
        div_clr  = sample;
        shift_en = sample;
      end
      STOP: begin
        sample  = (div == BIT_END);
        div_clr = sample;
        load    = sample && rx_s;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      irq     <= 1'b0;
    end else begin
      div <= div_clr ? '0 : div + 1'b1;
      if (state == START) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (shift_en) begin
        shift <= {rx_s, shift[DATA_BITS-1:1]};
      end
      if (load) begin
        data_q <= shift;
      end
      // A completing byte beats a simultaneous clear.
      if (load) begin
        irq <= 1'b1;
      end else if (bus.interrupt_clear) begin
        irq <= 1'b0;
      end
    end
  end

  assign bus.data      = data_q;
  assign bus.interrupt = irq;

endmodule

// File: tb/tb_uart1rx.sv
// Directed bench for uart1rx at CLOCK_DIV=16.
// Expected values are hand-computed frame results.
module tb_uart1rx;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  uart1rx_if bus ();

  uart1rx #(
    .CLOCK_DIV         (16),
    .CLOCK_COUNTER_BITS(8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [7:0] obs,
                       input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive_bits(input logic [9:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      bus.rx = f[i];
      tick(16);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    drive_bits({stop, b, 1'b0}, 10);
  endtask

  task automatic send_head(input logic [7:0] b);
    drive_bits({1'b1, b, 1'b0}, 9);
  endtask

  task automatic pulse_clear();
    bus.interrupt_clear = 1'b1;
    tick(1);
    bus.interrupt_clear = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.rx = 1'b1;
    bus.interrupt_clear = 1'b0;
    reset = 1'b1;
    tick(3);
    check("rst_data", bus.data, 8'h00);
    check("rst_irq", {7'd0, bus.interrupt}, 8'h00);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick(80);
      check("idle_data", bus.data, 8'h00);
      check("idle_irq", {7'd0, bus.interrupt}, 8'h00);
    end

    // Frame 0x55 with exact interrupt timing: rises 155 cycles after start edge.
    send_head(8'h55);
    bus.rx = 1'b1;
    tick(10);
    check("f1_irq_early", {7'd0, bus.interrupt}, 8'h00);
    tick(1);
    check("f1_irq_rise", {7'd0, bus.interrupt}, 8'h01);
    check("f1_data", bus.data, 8'h55);
    tick(5);

    send_frame(8'hA3, 1'b1);
    check("f2_data", bus.data, 8'hA3);
    check("f2_irq", {7'd0, bus.interrupt}, 8'h01);

    pulse_clear();
    check("clr_irq", {7'd0, bus.interrupt}, 8'h00);

    // Glitch shorter than half a bit.
    bus.rx = 1'b0;
    tick(3);
    bus.rx = 1'b1;
    tick(30);
    check("glitch_data", bus.data, 8'hA3);
    check("glitch_irq", {7'd0, bus.interrupt}, 8'h00);
    send_frame(8'h3C, 1'b1);
    check("f3c_data", bus.data, 8'h3C);
    check("f3c_irq", {7'd0, bus.interrupt}, 8'h01);
    pulse_clear();
    check("clr2_irq", {7'd0, bus.interrupt}, 8'h00);

    // Framing error then held low for three bit times.
    send_frame(8'hF0, 1'b0);
    tick(48);
    check("ferr_low_data", bus.data, 8'h3C);
    bus.rx = 1'b1;
    tick(20);
    check("ferr_data", bus.data, 8'h3C);
    check("ferr_irq", {7'd0, bus.interrupt}, 8'h00);
    send_frame(8'h81, 1'b1);
    check("f81_data", bus.data, 8'h81);
    check("f81_irq", {7'd0, bus.interrupt}, 8'h01);

    pulse_clear();
    check("clr3_irq", {7'd0, bus.interrupt}, 8'h00);
    pulse_clear();
    check("clr_idle_irq", {7'd0, bus.interrupt}, 8'h00);

    // Clear in the very cycle the byte completes.
    send_head(8'h5A);
    bus.rx = 1'b1;
    tick(10);
    bus.interrupt_clear = 1'b1;
    tick(1);
    bus.interrupt_clear = 1'b0;
    check("race_irq", {7'd0, bus.interrupt}, 8'h01);
    check("race_data", bus.data, 8'h5A);
    tick(5);

    // Reset during bit 4 of 0xFF.
    drive_bits({1'b1, 8'hFF, 1'b0}, 5);
    tick(8);
    reset = 1'b1;
    #2;
    check("mid_rst_data", bus.data, 8'h00);
    check("mid_rst_irq", {7'd0, bus.interrupt}, 8'h00);
    tick(3);
    reset = 1'b0;
    tick(20);
    check("post_rst_irq", {7'd0, bus.interrupt}, 8'h00);
    send_frame(8'h12, 1'b1);
    check("f12_data", bus.data, 8'h12);
    check("f12_irq", {7'd0, bus.interrupt}, 8'h01);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
